// File: rtl/timebase_gen_pkg.sv
// timebase_gen_pkg: shared clock-rate and default divisor constants for the timebase
package timebase_gen_pkg;
    localparam int CLK_HZ    = 50_000_000;
    localparam int DIV_10KHZ = CLK_HZ / 10_000;
    localparam int DIV_100HZ = CLK_HZ / 100;
    localparam int DIV_1HZ   = CLK_HZ;
    localparam int DIV_MIN   = 2;
endpackage

// File: rtl/timebase_gen_chan.sv
// timebase_gen_chan: one timebase channel with shadowed divisor, tick and square-wave outputs
module timebase_gen_chan
    import timebase_gen_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk50mhz,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_chen,
    input  logic [CNT_W-1:0] div_rst,
    input  logic             chen_rst,
    output logic             tick,
    output logic             sq
);
    logic [CNT_W-1:0] cnt, cnt_inc, div_shd, div_act, div_wr;
    logic             chen, wrap;

    always_comb begin
        div_wr  = (wr_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : wr_div;
        cnt_inc = cnt + CNT_W'(1);
        wrap    = cnt == div_act - CNT_W'(1);
    end

    // a disabled channel takes a same-cycle write directly so re-enable starts on the new divisor
    always_ff @(posedge clk50mhz) begin
        if (!en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            sq      <= 1'b0;
            div_shd <= div_rst;
            div_act <= div_rst;
            chen    <= chen_rst;
        end else begin
            if (wr) begin
                div_shd <= div_wr;
                chen    <= wr_chen;
            end
            if (chen && sync) begin
                cnt     <= '0;
                tick    <= 1'b0;
                sq      <= 1'b0;
                div_act <= div_shd;
            end else if (!chen) begin
                cnt     <= '0;
                tick    <= 1'b0;
                sq      <= 1'b0;
                div_act <= wr ? div_wr : div_shd;
            end else if (wrap) begin
                cnt     <= '0;
                tick    <= 1'b1;
                sq      <= 1'b0;
                div_act <= div_shd;
            end else begin
                cnt     <= cnt_inc;
                tick    <= 1'b0;
                sq      <= cnt_inc >= (div_act >> 1);
            end
        end
    end
endmodule

// File: rtl/timebase_gen.sv
// timebase_gen: multi-channel programmable timebase with write decode and per-channel instances
module timebase_gen
    import timebase_gen_pkg::*;
#(
    parameter int                   NCH      = 3,
    parameter int                   CNT_W    = 28,
    parameter logic [NCH*CNT_W-1:0] DIV_RST  = {28'(DIV_1HZ), 28'(DIV_100HZ), 28'(DIV_10KHZ)},
    parameter logic [NCH-1:0]       CHEN_RST = {NCH{1'b1}}
) (
    input  logic             clk50mhz,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [2:0]       wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_chen,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);
    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        timebase_gen_chan #(.CNT_W(CNT_W)) u_chan (
            .clk50mhz(clk50mhz),
            .en(en),
            .sync(sync),
            .wr(wr_en && int'(wr_ch) == i && int'(wr_ch) < NCH),
            .wr_div(wr_div),
            .wr_chen(wr_chen),
            .div_rst(DIV_RST[i*CNT_W +: CNT_W]),
            .chen_rst(CHEN_RST[i]),
            .tick(tick[i]),
            .sq(sq[i])
        );
    end
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: scoreboard bench; a timestamp-based reference model predicts tick/sq per cycle
module tb_timebase_gen;
    logic        clk50mhz = 1'b0;
    logic        en = 1'b0, sync = 1'b0, wr_en = 1'b0, wr_chen = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [27:0] wr_div = '0;
    logic [2:0]  tick, sq;
    int          errors = 0, checks = 0, tick0_cnt = 0;
    longint      t = 0, cyc = 0;
    logic [5:0]  q[$];
    int          drst[3] = '{5000, 500000, 50000000};
    int          shd[3], act[3];
    bit          ce[3];
    longint      nxt[3];

    timebase_gen dut (
        .clk50mhz(clk50mhz), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .wr_chen(wr_chen), .tick(tick), .sq(sq)
    );

    always #5 clk50mhz = ~clk50mhz;

    // model: each channel remembers the absolute edge of its next tick; sq follows from phase arithmetic
    task automatic drive(input bit e, input bit s, input bit w, input int ch, input int d, input bit c);
        logic [2:0] et, es;
        bit         wv;
        int         dv;
        @(negedge clk50mhz);
        en = e; sync = s; wr_en = w; wr_ch = 3'(ch); wr_div = 28'(d); wr_chen = c;
        t++;
        dv = d < 2 ? 2 : d;
        for (int k = 0; k < 3; k++) begin
            wv = w && ch == k;
            et[k] = 1'b0;
            es[k] = 1'b0;
            if (!e) begin
                shd[k] = drst[k]; act[k] = drst[k]; ce[k] = 1'b1; nxt[k] = t + act[k];
            end else begin
                if (s && ce[k]) begin
                    act[k] = shd[k]; nxt[k] = t + act[k];
                end else if (!ce[k]) begin
                    act[k] = wv ? dv : shd[k]; nxt[k] = t + act[k];
                end else if (t == nxt[k]) begin
                    et[k] = 1'b1; act[k] = shd[k]; nxt[k] = t + act[k];
                end else
                    es[k] = (act[k] - (nxt[k] - t)) >= act[k] / 2;
                if (wv) begin
                    shd[k] = dv; ce[k] = c;
                end
            end
        end
        q.push_back({et, es});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [5:0] exp;
        forever begin
            @(posedge clk50mhz);
            #1;
            cyc++;
            if (tick[0]) tick0_cnt++;
            if (q.size() != 0) begin
                exp = q.pop_front();
                checks++;
                if ({tick, sq} !== exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got tick=%b sq=%b want tick=%b sq=%b",
                             cyc, tick, sq, exp[5:3], exp[2:0]);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) drive(0, 0, 0, 0, 0, 1);
        tick0_cnt = 0;
        idle(50000);
        @(posedge clk50mhz);
        #2;
        checks++;
        if (tick0_cnt != 10) begin
            errors++;
            $display("FAIL tick0_pulses_1ms got %0d want 10", tick0_cnt);
        end
        drive(1, 0, 1, 1, 10, 1);
        idle(13);
        drive(1, 0, 1, 0, 0, 1);
        idle(20);
        drive(1, 0, 1, 0, 1, 1);
        drive(1, 0, 1, 5, 3, 0);
        idle(20);
        drive(1, 0, 1, 0, 7, 1);
        idle(25);
        drive(1, 1, 0, 0, 0, 1);
        idle(30);
        drive(1, 0, 1, 2, 9, 0);
        idle(10);
        drive(1, 0, 1, 2, 4, 1);
        idle(30);
        drive(0, 0, 1, 1, 3, 1);
        drive(0, 0, 0, 0, 0, 1);
        idle(5100);
        repeat (20000)
            drive($urandom_range(0, 1999) != 0, $urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 24)), $urandom_range(0, 7) != 0);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk50mhz);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
